lsu_byte_seq: RTL and testbench

Load/store sequencer between the execute stage and the 32×8 data memory. It accepts one 32-bit load or store request per handshake and breaks it into sequential single-byte memory accesses, in little-endian order. It assembles and sign- or zero-extends load data, then returns a response through a valid/ready handshake. The block is the only driver of the data memory's write-enable, address and write-data inputs.

---
 rtl/lsu_byte_seq.sv | 104 ++++++++++
 tb/tb_lsu_byte_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: splits 32-bit load/store requests into sequential little-endian byte accesses.
// Optional macro LSU_MISALIGN_SPLIT_EN lets misaligned half/word accesses run byte-by-byte instead of erroring.
module lsu_byte_seq #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]        size_q, size_d, idx_q, idx_d, last;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              misalign, req_err, access, sign;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign misalign = 1'b0;
`else
  assign misalign = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
  assign req_err = (req_size == 2'b11) || misalign;
  assign last    = size_q == 2'b00 ? 2'd0 : size_q == 2'b01 ? 2'd1 : 2'd3;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        uns_d   = req_unsigned;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        idx_d   = 2'd0;
        rdata_d = 32'd0;
        err_d   = req_err;
        state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!we_q) rdata_d[{idx_q, 3'b000} +: 8] = mem_rdata;
        idx_d = idx_q + 2'd1;
        if (idx_q == last) state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign access     = state_q == ACCESS;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid && err_q;
  assign mem_we     = access && we_q;
  assign mem_addr   = access ? addr_q + ADDR_W'(idx_q) : '0;
  assign mem_wdata  = mem_we ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign sign       = !uns_q && (size_q == 2'b00 ? rdata_q[7] : rdata_q[15]);
  // Extension is applied on the way out so the raw captured lanes stay untouched.
  assign resp_rdata = !(resp_valid && !we_q && !err_q) ? 32'd0 :
                      size_q == 2'b00 ? {{24{sign}}, rdata_q[7:0]} :
                      size_q == 2'b01 ? {{16{sign}}, rdata_q[15:0]} : rdata_q;
endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed checks of lsu_byte_seq against a behavioural 32-byte memory.
module tb_lsu_byte_seq;
  logic        clk = 1'b0, rst_n = 1'b0, init = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [32];
  int          we_cnt = 0;
  int          tests = 0, fails = 0;
  int          lat, nw;
  logic [31:0] rd, r0;
  logic        er;

  always #5 clk = ~clk;

  lsu_byte_seq #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [4:0] a,
                        input logic [31:0] wd, output int l, output logic [31:0] r,
                        output logic e, output int n);
    int w0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    w0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = 32'hDEAD_BEEF;
    l = 1;
    while (!resp_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    r = resp_rdata; e = resp_err; n = we_cnt - w0;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk); init = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 2'b10, 1'b0, 5'd4, 32'h8180FF7F, lat, rd, er, nw);
    chk("st_w_lat", 32'(lat), 32'd5);
    chk("st_w_err", 32'(er), 32'd0);
    chk("st_w_rdata", rd, 32'd0);
    chk("st_w_nw", 32'(nw), 32'd4);
    chk("st_w_mem", {mem[7], mem[6], mem[5], mem[4]}, 32'h8180FF7F);

    do_req(1'b0, 2'b10, 1'b0, 5'd4, 32'h0, lat, rd, er, nw);
    chk("ld_w_lat", 32'(lat), 32'd5);
    chk("ld_w_rdata", rd, 32'h8180FF7F);
    chk("ld_w_err", 32'(er), 32'd0);
    chk("ld_w_nw", 32'(nw), 32'd0);

    do_req(1'b0, 2'b00, 1'b0, 5'd5, 32'h0, lat, rd, er, nw);
    chk("ld_bs_lat", 32'(lat), 32'd2);
    chk("ld_bs_rdata", rd, 32'hFFFFFFFF);
    do_req(1'b0, 2'b00, 1'b1, 5'd5, 32'h0, lat, rd, er, nw);
    chk("ld_bu_rdata", rd, 32'h000000FF);
    do_req(1'b0, 2'b00, 1'b0, 5'd4, 32'h0, lat, rd, er, nw);
    chk("ld_bs_pos_rdata", rd, 32'h0000007F);
    do_req(1'b0, 2'b01, 1'b0, 5'd6, 32'h0, lat, rd, er, nw);
    chk("ld_hs_lat", 32'(lat), 32'd3);
    chk("ld_hs_rdata", rd, 32'hFFFF8180);
    do_req(1'b0, 2'b01, 1'b1, 5'd6, 32'h0, lat, rd, er, nw);
    chk("ld_hu_rdata", rd, 32'h00008180);
    do_req(1'b0, 2'b01, 1'b0, 5'd4, 32'h0, lat, rd, er, nw);
    chk("ld_hs_pos_rdata", rd, 32'hFFFFFF7F);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b1, 2'b10, 1'b0, 5'd30, 32'h44332211, lat, rd, er, nw);
    chk("split_st_lat", 32'(lat), 32'd5);
    chk("split_st_err", 32'(er), 32'd0);
    chk("split_st_mem", {mem[1], mem[0], mem[31], mem[30]}, 32'h44332211);
    do_req(1'b0, 2'b10, 1'b0, 5'd30, 32'h0, lat, rd, er, nw);
    chk("split_ld_rdata", rd, 32'h44332211);
    chk("split_ld_err", 32'(er), 32'd0);
`else
    do_req(1'b0, 2'b10, 1'b0, 5'd2, 32'h0, lat, rd, er, nw);
    chk("mis_ld_lat", 32'(lat), 32'd1);
    chk("mis_ld_err", 32'(er), 32'd1);
    chk("mis_ld_rdata", rd, 32'd0);
    chk("mis_ld_nw", 32'(nw), 32'd0);
    do_req(1'b1, 2'b01, 1'b0, 5'd5, 32'h12345678, lat, rd, er, nw);
    chk("mis_st_err", 32'(er), 32'd1);
    chk("mis_st_nw", 32'(nw), 32'd0);
    chk("mis_st_mem", {mem[6], mem[5]}, 32'h80FF);
`endif

    do_req(1'b1, 2'b11, 1'b0, 5'd0, 32'hFFFFFFFF, lat, rd, er, nw);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_err", 32'(er), 32'd1);
    chk("ill_rdata", rd, 32'd0);
    chk("ill_nw", 32'(nw), 32'd0);

    resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 5'd4, 32'h0, lat, rd, er, nw);
    chk("hold_lat", 32'(lat), 32'd5);
    r0 = rd;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, 32'h8180FF7F);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    chk("hold_first_rdata", r0, 32'h8180FF7F);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_resp_valid", 32'(resp_valid), 32'd0);

    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 5'd8; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_mid_addr", 32'(mem_addr), 32'd10);
    chk("ar_mid_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_req_ready", 32'(req_ready), 32'd1);
    chk("ar_resp_valid", 32'(resp_valid), 32'd0);
    chk("ar_mem_we", 32'(mem_we), 32'd0);
    chk("ar_mem_addr", 32'(mem_addr), 32'd0);
    chk("ar_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("ar_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("ar_mem_8", 32'(mem[8]), 32'hDD);
    chk("ar_mem_9", 32'(mem[9]), 32'hCC);
    chk("ar_mem_10", 32'(mem[10]), 32'h0A);
    @(posedge clk); #1;
    do_req(1'b0, 2'b00, 1'b1, 5'd9, 32'h0, lat, rd, er, nw);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_rdata", rd, 32'h000000CC);
    do_req(1'b0, 2'b01, 1'b0, 5'd8, 32'h0, lat, rd, er, nw);
    chk("post_rst_half", rd, 32'hFFFFCCDD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
